// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: shared types and defaults for the stream_mux_rr slice.
//   mode_e          : arbitration mode (round-robin / fixed select)
//   DEF_DATA_WIDTH  : default payload width
//   DEF_NUM_CH      : default number of input channels
//   next_ch()       : wrap-around increment of a channel index
package stream_mux_pkg;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_CH     = 5;

    // Index following ch, wrapping num_ch-1 back to 0.
    function automatic int next_ch(input int ch, input int num_ch);
        return (ch >= num_ch - 1) ? 0 : ch + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: bundles the upstream (N-channel) and downstream
// (single-channel) valid/ready signals of stream_mux_rr.
//   slave  : view of the multiplexer itself
//   master : view of the environment driving/consuming it
// With STREAM_MUX_PKT_LOCK_EN defined, last_i/last_o are added.
interface stream_mux_rr_if
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) ();
    logic                         mode_i;
    logic [SEL_WIDTH-1:0]         sel_i;
    logic [NUM_CH-1:0]            valid_i;
    logic [NUM_CH*DATA_WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]            ready_o;
    logic                         valid_o;
    logic [DATA_WIDTH-1:0]        data_o;
    logic [SEL_WIDTH-1:0]         ch_o;
    logic                         ready_i;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [NUM_CH-1:0]            last_i;
    logic                         last_o;
`endif

    modport slave (
        input  mode_i, sel_i, valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, ch_o
`ifdef STREAM_MUX_PKT_LOCK_EN
        , input last_i, output last_o
`endif
    );

    modport master (
        output mode_i, sel_i, valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, ch_o
`ifdef STREAM_MUX_PKT_LOCK_EN
        , output last_i, input last_o
`endif
    );
endinterface

// File: rtl/stream_mux_rr_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with its own pointer register.
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   req            : per-channel request
//   adv_en         : advance pointer past the current winner
//   grant, winner  : one-hot grant and its index (grant==0 -> no winner)
// With STREAM_MUX_PKT_LOCK_EN defined:
//   xfer_en, xfer_ch, xfer_last : a beat moved on xfer_ch; last flag
//   locked                      : arbiter is held on a packet's channel
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv_en,
`ifdef STREAM_MUX_PKT_LOCK_EN
    input  logic              xfer_en,
    input  logic [IDX_W-1:0]  xfer_ch,
    input  logic              xfer_last,
    output logic              locked,
`endif
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  winner
);
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [NUM_CH-1:0] grant_rr;
    logic [IDX_W-1:0]  win_rr;
    logic              rr_hit;
    int                idx;
    logic [IDX_W-1:0]  idx_s;

    // First requester at or above the pointer, wrapping at NUM_CH.
    always_comb begin
        rr_hit = 1'b0;
        win_rr = '0;
        idx    = 0;
        idx_s  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_reg) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            idx_s = IDX_W'(idx);
            if (!rr_hit && req[idx_s]) begin
                rr_hit = 1'b1;
                win_rr = idx_s;
            end
        end
        grant_rr = rr_hit ? (NUM_CH'(1) << win_rr) : '0;
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic             lock_reg;
    logic [IDX_W-1:0] lock_ch_reg;

    // Mid-packet: only the owning channel may be granted.
    assign locked = lock_reg;
    assign grant  = lock_reg ? ((NUM_CH'(1) << lock_ch_reg) & req) : grant_rr;
    assign winner = lock_reg ? lock_ch_reg : win_rr;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lock_reg    <= 1'b0;
            lock_ch_reg <= '0;
        end else if (xfer_en) begin
            lock_reg    <= !xfer_last;
            lock_ch_reg <= xfer_ch;
        end
    end
`else
    assign grant  = grant_rr;
    assign winner = win_rr;
`endif

    assign ptr_next = adv_en ? IDX_W'(next_ch(int'(winner), NUM_CH)) : ptr_reg;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) ptr_reg <= '0;
        else          ptr_reg <= ptr_next;
    end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with a single
// registered output stage. Channel choice is round-robin (mode_i=0) or a
// fixed index sel_i (mode_i=1).
//   clk_i, arstn_i : clock, asynchronous active-low reset
//   bus (slave)    : mode_i, sel_i, valid_i, data_i -> ready_o;
//                    valid_o, data_o, ch_o <- ready_i
// Optional: STREAM_MUX_PKT_LOCK_EN adds last_i/last_o and holds arbitration
// on one channel until its packet's last beat.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int SEL_WIDTH  = $clog2(NUM_CH)
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    stream_mux_rr_if.slave bus
);
    mode_e                  mode;
    logic                   load_en;
    logic                   xfer;
    logic                   use_arb;
    logic                   sel_ok;
    logic [NUM_CH-1:0]      arb_grant, fix_grant, grant;
    logic [SEL_WIDTH-1:0]   arb_winner, win;
    logic [DATA_WIDTH-1:0]  ch_data [NUM_CH];

    logic                   valid_reg;
    logic [DATA_WIDTH-1:0]  data_reg;
    logic [SEL_WIDTH-1:0]   ch_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign ch_data[gi] = bus.data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign mode    = mode_e'(bus.mode_i);
    assign load_en = !valid_reg || bus.ready_i;

    // Out-of-range select grants nobody.
    assign sel_ok    = ({1'b0, bus.sel_i} < (SEL_WIDTH+1)'(NUM_CH));
    assign fix_grant = sel_ok ? ((NUM_CH'(1) << bus.sel_i) & bus.valid_i) : '0;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic locked;
    logic last_reg;
    assign use_arb = (mode == MODE_RR) || locked;
`else
    assign use_arb = (mode == MODE_RR);
`endif

    assign grant = use_arb ? arb_grant : fix_grant;
    assign win   = use_arb ? arb_winner : bus.sel_i;

    // ready_o is forced low during reset since the register cannot load.
    assign bus.ready_o = arstn_i ? (grant & {NUM_CH{load_en}}) : '0;
    assign xfer        = |bus.ready_o;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(SEL_WIDTH)) u_arb (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .req       (bus.valid_i),
        .adv_en    (xfer && (mode == MODE_RR)),
`ifdef STREAM_MUX_PKT_LOCK_EN
        .xfer_en   (xfer),
        .xfer_ch   (win),
        .xfer_last (bus.last_i[win]),
        .locked    (locked),
`endif
        .grant     (arb_grant),
        .winner    (arb_winner)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            ch_reg    <= '0;
        end else if (xfer) begin
            valid_reg <= 1'b1;
            data_reg  <= ch_data[win];
            ch_reg    <= win;
        end else if (bus.ready_i) begin
            valid_reg <= 1'b0;
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i)  last_reg <= 1'b0;
        else if (xfer) last_reg <= bus.last_i[win];
    end
    assign bus.last_o = last_reg;
`endif

    assign bus.valid_o = valid_reg;
    assign bus.data_o  = data_reg;
    assign bus.ch_o    = ch_reg;
endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;
    import stream_mux_pkg::*;

    localparam int DW = 64;
    localparam int N  = 5;
    localparam int SW = $clog2(N);

    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    stream_mux_rr_if #(.DATA_WIDTH(DW), .NUM_CH(N), .SEL_WIDTH(SW)) bus ();

    stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(N), .SEL_WIDTH(SW)) dut (
        .clk_i   (clk),
        .arstn_i (arstn),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the output register must hold.
    int            m_ptr;
    bit            m_v;
    logic [DW-1:0] m_d;
    int            m_ch;
    bit            m_lock;
    int            m_lch;
    bit            m_last;

    int rr_exp [6] = '{0, 1, 2, 3, 4, 0};
    int wr_exp [3] = '{0, 1, 0};
    int lk_exp [4] = '{1, 1, 1, 0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_v = 0; m_d = '0; m_ch = 0; m_lock = 0; m_lch = 0; m_last = 0;
    endtask

    // Which channel the rules say must be granted this cycle (-1: none).
    function automatic int m_win();
        if (m_lock) return bus.valid_i[m_lch] ? m_lch : -1;
        if (bus.mode_i == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                int c = (m_ptr + i) % N;
                if (bus.valid_i[c]) return c;
            end
            return -1;
        end
        if (int'(bus.sel_i) < N && bus.valid_i[bus.sel_i]) return int'(bus.sel_i);
        return -1;
    endfunction

    task automatic set_data(input int k, input logic [DW-1:0] v);
        bus.data_i[k*DW +: DW] = v;
    endtask

    // One clock: compare every output to the model, then advance both.
    task automatic step();
        int w;
        bit ld;
        logic [N-1:0] exp_r;
        #1;
        w  = m_win();
        ld = !m_v || bus.ready_i;
        exp_r = (w >= 0 && ld) ? (N'(1) << w) : '0;
        chk("ready_o", 64'(bus.ready_o), 64'(exp_r));
        chk("valid_o", 64'(bus.valid_o), 64'(m_v));
        chk("data_o",  bus.data_o, m_d);
        chk("ch_o",    64'(bus.ch_o), 64'(m_ch));
`ifdef STREAM_MUX_PKT_LOCK_EN
        chk("last_o",  64'(bus.last_o), 64'(m_last));
`endif
        @(posedge clk);
        if (exp_r != '0) begin
            m_v  = 1;
            m_d  = bus.data_i[w*DW +: DW];
            m_ch = w;
            if (bus.mode_i == 1'b0) m_ptr = (w + 1) % N;
`ifdef STREAM_MUX_PKT_LOCK_EN
            m_last = bus.last_i[w];
            m_lock = !bus.last_i[w];
            m_lch  = w;
`endif
        end else if (bus.ready_i) begin
            m_v = 0;
        end
        #1;
    endtask

    initial begin
        model_reset();
        bus.mode_i  = 1'b0;
        bus.sel_i   = '0;
        bus.valid_i = 5'b11111;
        bus.ready_i = 1'b1;
        for (int k = 0; k < N; k++) set_data(k, 64'h1000 + 64'(k));
`ifdef STREAM_MUX_PKT_LOCK_EN
        bus.last_i = '1;
`endif
        // Reset state
        #12;
        chk("rst_ready_o", 64'(bus.ready_o), 64'h0);
        chk("rst_valid_o", 64'(bus.valid_o), 64'h0);
        chk("rst_data_o",  bus.data_o, 64'h0);
        chk("rst_ch_o",    64'(bus.ch_o), 64'h0);
        @(negedge clk);
        arstn = 1'b1;

        // Round-robin fairness
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_seq_ch", 64'(bus.ch_o), 64'(rr_exp[i]));
            chk("rr_seq_valid", 64'(bus.valid_o), 64'h1);
        end

        // Backpressure
        bus.valid_i = 5'b00100;
        set_data(2, 64'hA5);
        step();
        chk("bp_capture", bus.data_o, 64'hA5);
        bus.ready_i = 1'b0;
        set_data(2, 64'h5A);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_data", bus.data_o, 64'hA5);
            chk("bp_hold_ch", 64'(bus.ch_o), 64'h2);
            chk("bp_ready_low", 64'(bus.ready_o), 64'h0);
        end
        bus.ready_i = 1'b1;
        #1;
        chk("bp_resume_ready", 64'(bus.ready_o), 64'h4);
        step();
        chk("bp_next_data", bus.data_o, 64'h5A);

        // Fixed select
        bus.mode_i  = 1'b1;
        bus.sel_i   = 3'd3;
        bus.valid_i = 5'b11111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fix_ch", 64'(bus.ch_o), 64'h3);
        end
        bus.sel_i = 3'd6;
        #1;
        chk("fix_oob_ready", 64'(bus.ready_o), 64'h0);
        step();
        chk("fix_oob_drain", 64'(bus.valid_o), 64'h0);
        chk("fix_oob_ch_hold", 64'(bus.ch_o), 64'h3);

        // Pointer wrap/skip: park pointer at 4, then only ch0/ch1 valid
        bus.mode_i  = 1'b0;
        bus.valid_i = 5'b01000;
        step();
        bus.valid_i = 5'b00011;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wrap_ch", 64'(bus.ch_o), 64'(wr_exp[i]));
        end

        // Asynchronous reset between edges
        #2;
        arstn = 1'b0;
        #1;
        chk("arst_valid_o", 64'(bus.valid_o), 64'h0);
        chk("arst_data_o",  bus.data_o, 64'h0);
        chk("arst_ch_o",    64'(bus.ch_o), 64'h0);
        chk("arst_ready_o", 64'(bus.ready_o), 64'h0);
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        bus.valid_i = 5'b11111;
        step();
        chk("arst_restart_ch", 64'(bus.ch_o), 64'h0);

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Packet lock: ch0 single beat, then 3-beat packet on ch1
        bus.ready_i = 1'b1;
        bus.last_i  = 5'b11111;
        bus.valid_i = 5'b00001;
        step();
        bus.valid_i = 5'b00011;
        bus.last_i  = 5'b11101;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.last_i = 5'b11111;
            step();
            chk("lock_ch", 64'(bus.ch_o), 64'(lk_exp[i]));
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.mode_i  = ($urandom_range(3) == 0);
            bus.sel_i   = 3'($urandom_range(7));
            bus.valid_i = 5'($urandom);
            bus.ready_i = ($urandom_range(9) < 7);
            for (int k = 0; k < N; k++) set_data(k, {$urandom, $urandom});
`ifdef STREAM_MUX_PKT_LOCK_EN
            bus.last_i = 5'($urandom);
`endif
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
